round_tracker: RTL and testbench
================================

ROUND_TRACKER -- requirements
Module: round_tracker

Interface
REQ-001 SHALL have parameter SHOTS, 3, shots granted per bird.
REQ-002 SHALL have parameter BIRDS, 10, birds per game.
REQ-003 SHALL have parameter FLY_FRAMES, 300, frame ticks before an unshot bird flies away.
REQ-004 SHALL have parameter HIT_POINTS, 500, score added per hit.
REQ-005 SHALL have parameter PASS_HITS, 6, hits needed to pass.
REQ-006 SHALL have port Clk input 1, system clock.
REQ-007 SHALL have port Reset input 1, synchronous, active-high reset.
REQ-008 SHALL have ports new_round, reset_shots, reset_score, reset_birds, each input 1, level commands from game control.
REQ-009 SHALL have port trigger input 1, one-cycle gun-fire pulse.
REQ-010 SHALL have port hit input 1, duck-under-crosshair, valid only with trigger.
REQ-011 SHALL have port frame_tick input 1, one-cycle pulse per video frame.
REQ-012 SHALL have ports no_shots_left, flew_away, bird_shot, game_over, passed, each output 1, level status to game control.
REQ-013 SHALL have ports shots_left output 2, birds_done output 4, hit_mask output BIRDS, and score output 16, for display.

Function
REQ-014 SHALL implement FSM IDLE, ACTIVE, RESOLVED; all registers update on rising Clk.
REQ-015 Command priority SHALL be Reset > reset_birds/reset_score/reset_shots (independent) > new_round > trigger/frame_tick.
REQ-016 new_round in any state with birds_done<BIRDS SHALL go ACTIVE, set shots_left=SHOTS, timer=0, and clear flew_away and bird_shot.
REQ-017 new_round while ACTIVE SHALL restart the bird without counting it; with birds_done==BIRDS it SHALL be ignored (state IDLE).
REQ-018 In ACTIVE, trigger with shots_left>0 SHALL decrement shots_left; trigger with shots_left==0 or outside ACTIVE SHALL be ignored.
REQ-019 Accepted trigger with hit=1 SHALL resolve as hit: next cycle bird_shot=1, hit_mask[birds_done] set, score+=HIT_POINTS saturating at 65535, birds_done+1, state RESOLVED.
REQ-020 hit without trigger SHALL have no effect.
REQ-021 In ACTIVE, frame_tick SHALL increment timer; when the incremented timer reaches FLY_FRAMES, next cycle flew_away=1, birds_done+1, state RESOLVED, mask bit left 0.
REQ-022 Accepted hit and final fly-away tick in the same cycle SHALL resolve as hit.
REQ-023 no_shots_left SHALL equal (shots_left==0) AND NOT bird_shot, so a last-shot hit never raises it.
REQ-024 bird_shot and flew_away SHALL hold until new_round, reset_birds or Reset.
REQ-025 game_over SHALL be combinational (birds_done==BIRDS); passed SHALL be combinational (popcount(hit_mask)>=PASS_HITS).
REQ-026 birds_done, score and game_over SHALL be updated on the same edge that raises bird_shot/flew_away.
REQ-027 reset_shots SHALL load shots_left=SHOTS without changing state.
REQ-028 reset_score SHALL clear score; reset_birds SHALL clear birds_done, hit_mask, bird_shot, flew_away and go IDLE.
REQ-029 RESOLVED SHALL ignore trigger and frame_tick until new_round.

Reset
REQ-030 Reset SHALL force IDLE, shots_left=SHOTS, timer=0, score=0, birds_done=0, hit_mask=0, bird_shot=0, flew_away=0, mid-operation included.
REQ-031 After Reset, outputs SHALL be no_shots_left=0, game_over=0, and passed=0.

Verification
REQ-032 new_round, trigger+hit on cycle 5 -> bird_shot=1 next cycle, shots_left=2, score=500, birds_done=1, hit_mask=0x001.
REQ-033 new_round, 3 triggers without hit -> no_shots_left=1; after 300 frame_ticks total -> flew_away=1, birds_done=1, score=0.
REQ-034 Third trigger with hit=1 -> bird_shot=1, no_shots_left stays 0 in every cycle.
REQ-035 Trigger+hit on the same cycle as the 300th frame_tick -> bird_shot=1, flew_away=0.
REQ-036 Ten birds: six hit, four fly away -> game_over=1, passed=1, score=3000; a further new_round is ignored.
REQ-037 Reset asserted mid-ACTIVE with shots_left=1 -> next cycle IDLE, shots_left=3, all status outputs 0.

Source files
------------

// File: rtl/round_tracker.sv
// round_tracker: per-bird shot, fly-away and score bookkeeping for one game.
// Ports: Clk/Reset (sync, active-high); level commands new_round, reset_shots,
//   reset_score, reset_birds; pulses trigger (with hit), frame_tick;
//   status no_shots_left, flew_away, bird_shot, game_over, passed;
//   display shots_left, birds_done, hit_mask, score.
module round_tracker #(
  parameter int SHOTS      = 3,
  parameter int BIRDS      = 10,
  parameter int FLY_FRAMES = 300,
  parameter int HIT_POINTS = 500,
  parameter int PASS_HITS  = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             new_round,
  input  logic             reset_shots,
  input  logic             reset_score,
  input  logic             reset_birds,
  input  logic             trigger,
  input  logic             hit,
  input  logic             frame_tick,
  output logic             no_shots_left,
  output logic             flew_away,
  output logic             bird_shot,
  output logic             game_over,
  output logic             passed,
  output logic [1:0]       shots_left,
  output logic [3:0]       birds_done,
  output logic [BIRDS-1:0] hit_mask,
  output logic [15:0]      score
);

  localparam int TW = $clog2(FLY_FRAMES + 1);
  localparam logic [1:0]  LP_SHOTS = 2'(SHOTS);
  localparam logic [3:0]  LP_BIRDS = 4'(BIRDS);
  localparam logic [TW-1:0] LP_FLY = TW'(FLY_FRAMES);
  localparam logic [16:0] LP_PTS   = 17'(HIT_POINTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RESOLVED
  } state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_shots, w_shots;
  logic [TW-1:0]    r_timer, w_timer;
  logic [15:0]      r_score, w_score;
  logic [3:0]       r_birds, w_birds;
  logic [BIRDS-1:0] r_mask, w_mask;
  logic             r_shot, w_shot;
  logic             r_flew, w_flew;

  logic             w_cmd;
  logic             w_fire;
  logic             w_hit;
  logic             w_fly;
  logic [TW-1:0]    w_tmr_inc;
  logic [16:0]      w_sum;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_shots <= LP_SHOTS;
      r_timer <= '0;
      r_score <= '0;
      r_birds <= '0;
      r_mask  <= '0;
      r_shot  <= 1'b0;
      r_flew  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shots <= w_shots;
      r_timer <= w_timer;
      r_score <= w_score;
      r_birds <= w_birds;
      r_mask  <= w_mask;
      r_shot  <= w_shot;
      r_flew  <= w_flew;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_shots   = r_shots;
    w_timer   = r_timer;
    w_score   = r_score;
    w_birds   = r_birds;
    w_mask    = r_mask;
    w_shot    = r_shot;
    w_flew    = r_flew;
    w_cmd     = reset_birds | reset_score | reset_shots;
    w_fire    = (r_state == S_ACTIVE) && trigger && (r_shots != 2'd0);
    w_hit     = w_fire && hit;
    w_tmr_inc = r_timer + 1'b1;
    w_fly     = frame_tick && (w_tmr_inc == LP_FLY);
    w_sum     = {1'b0, r_score} + LP_PTS;

    // Any reset command this cycle masks new_round, trigger and ticks.
    if (w_cmd) begin
      if (reset_shots) w_shots = LP_SHOTS;
      if (reset_score) w_score = '0;
      if (reset_birds) begin
        w_birds = '0;
        w_mask  = '0;
        w_shot  = 1'b0;
        w_flew  = 1'b0;
        w_state = S_IDLE;
      end
    end else if (new_round) begin
      if (r_birds < LP_BIRDS) begin
        w_state = S_ACTIVE;
        w_shots = LP_SHOTS;
        w_timer = '0;
        w_shot  = 1'b0;
        w_flew  = 1'b0;
      end else begin
        w_state = S_IDLE;
      end
    end else if (r_state == S_ACTIVE) begin
      if (w_fire) w_shots = r_shots - 1'b1;
      if (frame_tick) w_timer = w_tmr_inc;
      // A hit wins over a fly-away landing on the same tick.
      if (w_hit) begin
        w_shot  = 1'b1;
        w_mask  = r_mask | (BIRDS'(1) << r_birds);
        w_score = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        w_birds = r_birds + 1'b1;
        w_state = S_RESOLVED;
      end else if (w_fly) begin
        w_flew  = 1'b1;
        w_birds = r_birds + 1'b1;
        w_state = S_RESOLVED;
      end
    end
  end

  assign shots_left    = r_shots;
  assign birds_done    = r_birds;
  assign hit_mask      = r_mask;
  assign score         = r_score;
  assign bird_shot     = r_shot;
  assign flew_away     = r_flew;
  assign no_shots_left = (r_shots == 2'd0) && !r_shot;
  assign game_over     = (r_birds == LP_BIRDS);
  assign passed        = ($countones(r_mask) >= PASS_HITS);

endmodule

// File: tb/tb_round_tracker.sv
// tb_round_tracker: directed scenarios plus random play
// against a behavioural game model.
module tb_round_tracker;

  logic        Clk = 1'b0;
  logic        Reset, new_round, reset_shots, reset_score;
  logic        reset_birds, trigger, hit, frame_tick;
  logic        no_shots_left, flew_away, bird_shot;
  logic        game_over, passed;
  logic [1:0]  shots_left;
  logic [3:0]  birds_done;
  logic [9:0]  hit_mask;
  logic [15:0] score;

  int checks = 0;
  int failures = 0;

  // reference game state
  bit       m_act;
  int       m_shots, m_timer, m_score, m_birds;
  bit [9:0] m_mask;
  bit       m_shot, m_flew;

  round_tracker dut (
    .Clk(Clk), .Reset(Reset),
    .new_round(new_round), .reset_shots(reset_shots),
    .reset_score(reset_score), .reset_birds(reset_birds),
    .trigger(trigger), .hit(hit), .frame_tick(frame_tick),
    .no_shots_left(no_shots_left), .flew_away(flew_away),
    .bird_shot(bird_shot), .game_over(game_over),
    .passed(passed), .shots_left(shots_left),
    .birds_done(birds_done), .hit_mask(hit_mask),
    .score(score)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (Reset) begin
      m_act = 0; m_shots = 3; m_timer = 0; m_score = 0;
      m_birds = 0; m_mask = '0; m_shot = 0; m_flew = 0;
    end else if (reset_birds || reset_score || reset_shots) begin
      if (reset_shots) m_shots = 3;
      if (reset_score) m_score = 0;
      if (reset_birds) begin
        m_birds = 0; m_mask = '0; m_shot = 0;
        m_flew = 0; m_act = 0;
      end
    end else if (new_round) begin
      if (m_birds < 10) begin
        m_act = 1; m_shots = 3; m_timer = 0;
        m_shot = 0; m_flew = 0;
      end else m_act = 0;
    end else if (m_act) begin
      acc = trigger && m_shots > 0;
      if (acc) m_shots--;
      if (frame_tick) m_timer++;
      if (acc && hit) begin
        m_shot = 1;
        m_mask[m_birds] = 1'b1;
        m_score = (m_score + 500 > 65535) ? 65535
                                          : m_score + 500;
        m_birds++;
        m_act = 0;
      end else if (frame_tick && m_timer == 300) begin
        m_flew = 1;
        m_birds++;
        m_act = 0;
      end
    end
  endtask

  task automatic cmp_all();
    chk("shots_left", int'(shots_left), m_shots);
    chk("birds_done", int'(birds_done), m_birds);
    chk("hit_mask", int'(hit_mask), int'(m_mask));
    chk("score", int'(score), m_score);
    chk("bird_shot", int'(bird_shot), int'(m_shot));
    chk("flew_away", int'(flew_away), int'(m_flew));
    chk("no_shots_left", int'(no_shots_left),
        int'(m_shots == 0 && !m_shot));
    chk("game_over", int'(game_over), int'(m_birds == 10));
    chk("passed", int'(passed),
        int'($countones(m_mask) >= 6));
  endtask

  task automatic clr();
    Reset = 0; new_round = 0; reset_shots = 0;
    reset_score = 0; reset_birds = 0;
    trigger = 0; hit = 0; frame_tick = 0;
  endtask

  // inputs are set by the caller; sample 1ns after the edge
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    cmp_all();
    clr();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1;
      tick();
    end
  endtask

  task automatic fresh();
    reset_birds = 1; reset_score = 1; reset_shots = 1;
    tick();
  endtask

  initial begin
    clr();
    Reset = 1;
    tick();
    chk("rst_shots", int'(shots_left), 3);
    chk("rst_noshots", int'(no_shots_left), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_passed", int'(passed), 0);
    chk("rst_score", int'(score), 0);

    // shot on cycle 5
    new_round = 1; tick();
    idle(3);
    trigger = 1; hit = 1; tick();
    chk("d32_shot", int'(bird_shot), 1);
    chk("d32_shots", int'(shots_left), 2);
    chk("d32_score", int'(score), 500);
    chk("d32_birds", int'(birds_done), 1);
    chk("d32_mask", int'(hit_mask), 1);

    // three misses then fly-away
    fresh();
    new_round = 1; tick();
    for (int i = 0; i < 3; i++) begin
      trigger = 1; tick();
    end
    chk("d33_noshots", int'(no_shots_left), 1);
    ticks(299);
    chk("d33_early", int'(flew_away), 0);
    ticks(1);
    chk("d33_flew", int'(flew_away), 1);
    chk("d33_birds", int'(birds_done), 1);
    chk("d33_score", int'(score), 0);

    // hit on the last shot
    fresh();
    new_round = 1; tick();
    trigger = 1; tick();
    trigger = 1; tick();
    trigger = 1; hit = 1; tick();
    chk("d34_shot", int'(bird_shot), 1);
    chk("d34_noshots", int'(no_shots_left), 0);
    idle(2);
    chk("d34_hold", int'(no_shots_left), 0);

    // hit ties with final tick
    new_round = 1; tick();
    ticks(299);
    frame_tick = 1; trigger = 1; hit = 1; tick();
    chk("d35_shot", int'(bird_shot), 1);
    chk("d35_flew", int'(flew_away), 0);

    // full game: six hits, four fly-aways
    fresh();
    for (int b = 0; b < 10; b++) begin
      new_round = 1; tick();
      if (b < 6) begin
        trigger = 1; hit = 1; tick();
      end else begin
        trigger = 1; tick();
        trigger = 1; tick();
        ticks(300);
      end
    end
    chk("d36_over", int'(game_over), 1);
    chk("d36_passed", int'(passed), 1);
    chk("d36_score", int'(score), 3000);
    chk("d36_mask", int'(hit_mask), 10'h03F);
    new_round = 1; tick();
    chk("d36_birds", int'(birds_done), 10);
    chk("d36_shots", int'(shots_left), 1);
    chk("d36_flew", int'(flew_away), 1);

    // Reset mid-bird
    fresh();
    new_round = 1; tick();
    trigger = 1; tick();
    trigger = 1; tick();
    chk("d37_pre", int'(shots_left), 1);
    Reset = 1; tick();
    chk("d37_shots", int'(shots_left), 3);
    chk("d37_shot", int'(bird_shot), 0);
    chk("d37_flew", int'(flew_away), 0);
    chk("d37_noshots", int'(no_shots_left), 0);
    chk("d37_over", int'(game_over), 0);
    chk("d37_passed", int'(passed), 0);
    trigger = 1; tick();
    chk("d37_idle", int'(shots_left), 3);

    // random play
    for (int c = 0; c < 30000; c++) begin
      Reset       = ($urandom_range(999) < 2);
      reset_birds = ($urandom_range(999) < 6);
      reset_score = ($urandom_range(999) < 4);
      reset_shots = ($urandom_range(999) < 8);
      new_round   = ($urandom_range(99) < 2);
      trigger     = ($urandom_range(99) < 8);
      hit         = ($urandom_range(99) < 35);
      frame_tick  = ($urandom_range(99) < 60);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
